// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit owning the HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div_q, sign_a, sign_b;
  logic [WIDTH-1:0]   b_q, rs_q;
  logic [2*WIDTH-1:0] pair, pair_nxt;

  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_up;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & rs_data[WIDTH-1];
  assign b_neg     = is_signed & rt_data[WIDTH-1];
  assign a_abs     = a_neg ? -rs_data : rs_data;
  assign b_abs     = b_neg ? -rt_data : rt_data;

  // Multiply: add into the upper half, then shift the whole pair right.
  assign mul_sum  = {1'b0, pair[2*WIDTH-1:WIDTH]} + {1'b0, (pair[0] ? b_q : {WIDTH{1'b0}})};
  // Divide: remainder after the left shift needs one extra bit to compare.
  assign div_up   = pair[2*WIDTH-1:WIDTH-1];
  assign div_ge   = div_up >= {1'b0, b_q};
  assign div_diff = div_up[WIDTH-1:0] - b_q;

  always_comb begin
    pair_nxt = pair;
    if (is_div_q) begin
      if (div_ge) pair_nxt = {div_diff, pair[WIDTH-2:0], 1'b1};
      else        pair_nxt = {pair[2*WIDTH-2:0], 1'b0};
    end else begin
      pair_nxt = {mul_sum, pair[WIDTH-1:1]};
    end
  end

  assign prod_fix = (sign_a ^ sign_b) ? -pair : pair;
  assign quo      = pair[WIDTH-1:0];
  assign rem      = pair[2*WIDTH-1:WIDTH];
  assign quo_fix  = (sign_a ^ sign_b) ? -quo : quo;
  assign rem_fix  = sign_a ? -rem : rem;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(ITER - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      is_div_q <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      b_q      <= '0;
      rs_q     <= '0;
      pair     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            is_div_q <= op[1];
            sign_a   <= a_neg;
            sign_b   <= b_neg;
            b_q      <= b_abs;
            rs_q     <= rs_data;
            pair     <= {{WIDTH{1'b0}}, a_abs};
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          pair <= pair_nxt;
          cnt  <= (cnt == CW'(ITER - 1)) ? '0 : cnt + CW'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div_q) begin
            {hi, lo} <= prod_fix;
          end else if (b_q == '0) begin
            hi <= rs_q;
            lo <= {WIDTH{1'b1}};
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wdata;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;
  exp_t sb[$];

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no result", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_hi", hi, e.hi);
        check("result_lo", lo, e.lo);
        check("result_cycle", cyc, e.at);
      end
    end
  end

  // Issue at a negedge; returns at the negedge following E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit expect_result);
    exp_t e;
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    if (expect_result) begin
      e.hi = eh; e.lo = el; e.at = cyc + 34;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  // From the negedge after E0, step to the done cycle (after E33).
  task automatic to_done();
    repeat (32) @(negedge clk);
    check("busy_in_fix", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("busy_in_done_cycle", {31'b0, busy}, 32'd0);
    check("done_pulse", {31'b0, done}, 32'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    issue(o, a, b, eh, el, 1'b1);
    to_done();
    @(negedge clk);
    check("done_clears", {31'b0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op(2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op(2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
    run_op(2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
    run_op(2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Disturb every input during RUN; the result must follow the latched operands.
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
    rs_data = 32'd9; rt_data = 32'd3; op = 2'b00;
    repeat (3) @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    repeat (24) @(negedge clk);
    check("busy_in_fix", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'd1);
    @(negedge clk);

    // Idle register writes.
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo_kept", lo, 32'd14);
    check("mthi_done", {31'b0, done}, 32'd0);
    mtlo = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi_kept", hi, 32'h1234);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFEF00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mtboth_hi", hi, 32'hCAFEF00D);
    check("mtboth_lo", lo, 32'hCAFEF00D);

    // start beats mthi in the same idle cycle.
    mthi = 1'b1; wdata = 32'hDEAD0000;
    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);
    mthi = 1'b0;
    check("start_prio_hi", hi, 32'hCAFEF00D);
    to_done();
    @(negedge clk);

    // Reset at E10 aborts the operation.
    issue(2'b00, 32'd1234, 32'd5678, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    repeat (30) @(negedge clk);
    check("abort_stays_idle", {31'b0, busy}, 32'd0);

    // Back-to-back: second start lands in the done cycle of the first.
    issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);
    to_done();
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    to_done();
    @(negedge clk);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
